// File: rtl/emux_tx_status.sv
// emux_tx_status
//   Terminating stage of the transmit client-mux chain. Forwards the 10-bit
//   chain bus to the MAC side with one cycle of latency. For each frame, it
//   captures the port and the length field, then counts and checksums the
//   payload. It emits a one-cycle status record at frame end or on abort.
//
// Ports
//   clk      sole clock, rising edge
//   rst      asynchronous, active-high reset
//   chain_c  chain bus: [9] m (payload active), [8] p (port strobe), [7:0] d
//   tx_c     chain_c delayed one cycle, unmodified
//   st_v     one-cycle status strobe per completed or aborted frame
//   st_port  captured port
//   st_len   captured length field
//   st_cnt   payload byte count, saturating at 0xFFFF
//   st_sum   ones-complement payload sum, not inverted
//   st_err   [0] len != cnt, [1] oversize, [2] header truncated, [3] aborted
module emux_tx_status #(
    parameter int unsigned jumbo_dw = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  chain_c,
    output logic [9:0]  tx_c,
    output logic        st_v,
    output logic [15:0] st_port,
    output logic [15:0] st_len,
    output logic [15:0] st_cnt,
    output logic [15:0] st_sum,
    output logic [3:0]  st_err
);

    localparam int unsigned LEN_MAX = (jumbo_dw >= 16) ? 32'hFFFF
                                                       : ((32'd1 << jumbo_dw) - 32'd1);

    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, GAP, PAY} state_t;

    state_t      state, state_n;
    logic        m, p;
    logic [7:0]  d, prev_d, hi;
    logic [15:0] port, len, cnt, sum;
    logic        pend, trunc;

    logic        do_start, do_count, do_fire, abort, set_trunc, cap_hi, cap_lo;
    logic [15:0] cnt_inc, sum_word, sum_final;
    logic        len_over;

    assign m = chain_c[9];
    assign p = chain_c[8];
    assign d = chain_c[7:0];

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always_comb begin
        cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        sum_word  = oc_add(sum, {hi, d});
        // An odd byte count leaves a high byte pending. Fold it in as {hi, 0x00}.
        sum_final = pend ? oc_add(sum, {hi, 8'h00}) : sum;
        len_over  = 32'(len) > LEN_MAX;
    end

    always_comb begin
        state_n   = state;
        do_start  = 1'b0;
        do_count  = 1'b0;
        do_fire   = 1'b0;
        abort     = 1'b0;
        set_trunc = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    do_start = 1'b1;
                    state_n  = LEN_H;
                end
            end
            LEN_H, LEN_L: begin
                if (p) begin
                    do_fire  = 1'b1;
                    abort    = 1'b1;
                    do_start = 1'b1;
                    state_n  = LEN_H;
                end else if (m) begin
                    set_trunc = 1'b1;
                    do_count  = 1'b1;
                    state_n   = PAY;
                end else if (state == LEN_H) begin
                    cap_hi  = 1'b1;
                    state_n = LEN_L;
                end else begin
                    cap_lo  = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (p) begin
                    do_fire  = 1'b1;
                    abort    = 1'b1;
                    do_start = 1'b1;
                    state_n  = LEN_H;
                end else if (m) begin
                    do_count = 1'b1;
                    state_n  = PAY;
                end
            end
            PAY: begin
                if (p && m) begin
                    // Abort wins and the colliding byte is not counted.
                    do_fire  = 1'b1;
                    abort    = 1'b1;
                    do_start = 1'b1;
                    state_n  = LEN_H;
                end else if (m) begin
                    do_count = 1'b1;
                end else begin
                    // Normal end. A p on this same edge starts the next frame.
                    do_fire = 1'b1;
                    if (p) begin
                        do_start = 1'b1;
                        state_n  = LEN_H;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_c    <= '0;
            prev_d  <= '0;
            port    <= '0;
            len     <= '0;
            cnt     <= '0;
            sum     <= '0;
            hi      <= '0;
            pend    <= 1'b0;
            trunc   <= 1'b0;
            st_v    <= 1'b0;
            st_port <= '0;
            st_len  <= '0;
            st_cnt  <= '0;
            st_sum  <= '0;
            st_err  <= '0;
        end else begin
            state  <= state_n;
            tx_c   <= chain_c;
            prev_d <= d;
            st_v   <= do_fire;
            if (do_fire) begin
                st_port <= port;
                st_len  <= len;
                st_cnt  <= cnt;
                st_sum  <= sum_final;
                st_err  <= {abort, trunc, len_over, cnt != len};
            end
            if (do_start) begin
                port  <= {prev_d, d};
                len   <= '0;
                cnt   <= '0;
                sum   <= '0;
                hi    <= '0;
                pend  <= 1'b0;
                trunc <= 1'b0;
            end else begin
                if (cap_hi)    len[15:8] <= d;
                if (cap_lo)    len[7:0]  <= d;
                if (set_trunc) trunc     <= 1'b1;
                if (do_count) begin
                    cnt <= cnt_inc;
                    if (pend) sum <= sum_word;
                    else      hi  <= d;
                    pend <= ~pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_emux_tx_status.sv
module tb_emux_tx_status;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  chain_c;
    logic [9:0]  tx_c;
    logic        st_v;
    logic [15:0] st_port, st_len, st_cnt, st_sum;
    logic [3:0]  st_err;

    int errors = 0;
    int checks = 0;
    int nv     = 0;

    emux_tx_status #(.jumbo_dw(11)) dut (
        .clk     (clk),
        .rst     (rst),
        .chain_c (chain_c),
        .tx_c    (tx_c),
        .st_v    (st_v),
        .st_port (st_port),
        .st_len  (st_len),
        .st_cnt  (st_cnt),
        .st_sum  (st_sum),
        .st_err  (st_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle, then verify the one-cycle forwarding of chain_c.
    task automatic step(input logic m, input logic p, input logic [7:0] d);
        logic [9:0] exp_tx;
        chain_c = {m, p, d};
        @(posedge clk);
        exp_tx = rst ? 10'h000 : chain_c;
        #1;
        checks++;
        if (tx_c !== exp_tx) begin
            errors++;
            $display("FAIL tx_delay: got %h expected %h", tx_c, exp_tx);
        end
        if (st_v === 1'b1) nv++;
    endtask

    task automatic send_hdr(input logic [15:0] port, input logic [15:0] len);
        step(1'b0, 1'b0, port[15:8]);
        step(1'b0, 1'b1, port[7:0]);
        step(1'b0, 1'b0, len[15:8]);
        step(1'b0, 1'b0, len[7:0]);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h5A);
        checks++;
        if ({st_v, st_port, st_len, st_cnt, st_sum, st_err} !== 69'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rec=%h expected all zero", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err});
        end
        rst = 1'b0;
        nv  = 0;
        // m without p in IDLE is ignored.
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL idle_m_ignored: got %0d strobes expected 0", nv);
        end
    endtask

    task automatic test_nominal;
        nv = 0;
        send_hdr(16'h1234, 16'd3);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL nominal_early_v: got %0d strobes expected 0", nv);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1) begin errors++; $display("FAIL nominal_v: got %b expected 1", st_v); end
        checks++;
        if (st_port !== 16'h1234) begin errors++; $display("FAIL nominal_port: got %h expected 1234", st_port); end
        checks++;
        if (st_len !== 16'h0003) begin errors++; $display("FAIL nominal_len: got %h expected 0003", st_len); end
        checks++;
        if (st_cnt !== 16'h0003) begin errors++; $display("FAIL nominal_cnt: got %h expected 0003", st_cnt); end
        checks++;
        if (st_sum !== 16'h0402) begin errors++; $display("FAIL nominal_sum: got %h expected 0402", st_sum); end
        checks++;
        if (st_err !== 4'b0000) begin errors++; $display("FAIL nominal_err: got %b expected 0000", st_err); end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b0 || st_port !== 16'h1234 || st_sum !== 16'h0402) begin
            errors++;
            $display("FAIL nominal_hold: got v=%b port=%h sum=%h expected v=0 port=1234 sum=0402",
                     st_v, st_port, st_sum);
        end
    endtask

    task automatic test_carry;
        send_hdr(16'h0A0B, 16'd4);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'h0A0B, 16'h0004, 16'h0004, 16'h0002, 4'b0000}) begin
            errors++;
            $display("FAIL carry_status: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'h0A0B, 16'h0004, 16'h0004, 16'h0002, 4'b0000});
        end
    endtask

    task automatic test_mismatch_oversize;
        send_hdr(16'h0001, 16'h0900);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'h0001, 16'h0900, 16'h0005, 16'h0906, 4'b0011}) begin
            errors++;
            $display("FAIL mismatch_oversize: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'h0001, 16'h0900, 16'h0005, 16'h0906, 4'b0011});
        end
    endtask

    task automatic test_abort;
        nv = 0;
        send_hdr(16'hAB01, 16'd5);
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h56);
        step(1'b1, 1'b1, 8'h78);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'hAB01, 16'h0005, 16'h0002, 16'h1156, 4'b1001}) begin
            errors++;
            $display("FAIL abort_status: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'hAB01, 16'h0005, 16'h0002, 16'h1156, 4'b1001});
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h9A);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'h5678, 16'h0001, 16'h0001, 16'h9A00, 4'b0000}) begin
            errors++;
            $display("FAIL abort_next_frame: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'h5678, 16'h0001, 16'h0001, 16'h9A00, 4'b0000});
        end
        checks++;
        if (nv !== 2) begin errors++; $display("FAIL abort_strobes: got %0d expected 2", nv); end
    endtask

    task automatic test_truncated;
        step(1'b0, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h07);
        step(1'b1, 1'b0, 8'h08);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'hAABB, 16'h0100, 16'h0002, 16'h0708, 4'b0101}) begin
            errors++;
            $display("FAIL truncated: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'hAABB, 16'h0100, 16'h0002, 16'h0708, 4'b0101});
        end
    endtask

    task automatic test_back_to_back;
        send_hdr(16'h0102, 16'd1);
        step(1'b1, 1'b0, 8'hC3);
        step(1'b0, 1'b1, 8'h4D);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'h0102, 16'h0001, 16'h0001, 16'hC300, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_first: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'h0102, 16'h0001, 16'h0001, 16'hC300, 4'b0000});
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'hC34D, 16'h0002, 16'h0002, 16'h1020, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_second: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'hC34D, 16'h0002, 16'h0002, 16'h1020, 4'b0000});
        end
    endtask

    task automatic test_reset_mid_frame;
        nv = 0;
        send_hdr(16'h7777, 16'd6);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h03);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h04);
        step(1'b1, 1'b0, 8'h05);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (nv !== 0) begin errors++; $display("FAIL reset_discard: got %0d strobes expected 0", nv); end
        send_hdr(16'h1234, 16'd3);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (st_v !== 1'b1 || {st_port, st_len, st_cnt, st_sum, st_err} !==
            {16'h1234, 16'h0003, 16'h0003, 16'h0402, 4'b0000}) begin
            errors++;
            $display("FAIL reset_next_frame: got v=%b rec=%h expected v=1 rec=%h", st_v,
                     {st_port, st_len, st_cnt, st_sum, st_err},
                     {16'h1234, 16'h0003, 16'h0003, 16'h0402, 4'b0000});
        end
    endtask

    initial begin
        rst     = 1'b1;
        chain_c = '0;
        test_reset;
        test_nominal;
        test_carry;
        test_mismatch_oversize;
        test_abort;
        test_truncated;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
